// File: rtl/common.sv
// Shared data-bus types for the memory pipeline stage and its attached RAM.
package common;

   typedef logic [63:0] word_t;
   typedef logic [63:0] addr_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic       valid;
      addr_t      addr;
      msize_t     size;
      logic [7:0] strobe;
      word_t      data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

endpackage

// File: rtl/ram_bank.sv
// DEPTH x 64-bit storage: byte-strobed synchronous write, registered read.
module ram_bank
   import common::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [7:0]    wstrb,
   input  logic [AW-1:0] waddr,
   input  word_t         wdata,
   input  logic [AW-1:0] raddr,
   output word_t         rdata
);

   word_t mem [DEPTH];
   word_t rdata_q, rdata_d;

   always_comb begin
      rdata_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dbus_ram.sv
// Fixed-latency data-bus RAM: one request in flight, response LATENCY cycles after
// the request is first seen; writes commit at the end of the response cycle.
module dbus_ram
   import common::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 1024,
   parameter logic [63:0] BASE    = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
);

   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    strobe_q, strobe_d;
   word_t         wdata_q, wdata_d;
   logic          in_range_q, in_range_d;

   addr_t         offset;
   logic          req_in_range;
   logic [AW-1:0] req_idx;
   logic [AW-1:0] raddr;
   logic          we;
   word_t         rdata;
   logic          unused_bits;

   always_comb begin
      offset       = dreq.addr - BASE;
      req_in_range = (dreq.addr >= BASE) && ((offset >> 3) < 64'(DEPTH));
      req_idx      = offset[AW+2:3];
   end

   assign unused_bits = ^{dreq.size, offset[63:AW+3], offset[2:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      strobe_d   = strobe_q;
      wdata_d    = wdata_q;
      in_range_d = in_range_q;
      unique case (state_q)
         IDLE: begin
            if (dreq.valid) begin
               idx_d      = req_idx;
               strobe_d   = dreq.strobe;
               wdata_d    = dreq.data;
               in_range_d = req_in_range;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         WAIT: begin
            if (!dreq.valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         strobe_q   <= '0;
         wdata_q    <= '0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         strobe_q   <= strobe_d;
         wdata_q    <= wdata_d;
         in_range_q <= in_range_d;
      end
   end

   // Read address tracks the live request while idle so LATENCY=1 still has data in RESP.
   assign raddr = (state_q == IDLE) ? req_idx : idx_q;
   assign we    = (state_q == RESP) && in_range_q && (|strobe_q) && !reset;

   ram_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram_bank (
      .clk   (clk),
      .we    (we),
      .wstrb (strobe_q),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      dresp.addr_ok = (state_q == RESP);
      dresp.data_ok = (state_q == RESP);
      dresp.data    = ((state_q == RESP) && in_range_q) ? rdata : '0;
   end

endmodule

// File: tb/tb_dbus_ram.sv
// Four DUTs at latencies 1/2/4/5 driven by directed steps; a scoreboard holds
// the expected response cycle and data for every accepted request.
module tb_dbus_ram;
   import common::*;

   localparam int unsigned DEPTH = 16;
   localparam logic [63:0] BASE  = 64'h8000_0000;

   function automatic int unsigned lat_of(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return 5;
      endcase
   endfunction

   typedef struct {
      int    k;
      int    cyc;
      word_t data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   dbus_req_t  dreq  [4];
   dbus_resp_t dresp [4];
   int         cyc   = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   exp_t       sb [$];
   word_t      model [4][DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dbus_ram #(
         .LATENCY (lat_of(g)),
         .DEPTH   (DEPTH),
         .BASE    (BASE)
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .dreq  (dreq[g]),
         .dresp (dresp[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request on DUT k, hold valid through the response cycle, then drop it.
   task automatic do_req(input int k, input logic [63:0] addr, input logic [7:0] strb,
                         input word_t wdata, input msize_t size);
      int    lat;
      int    idx;
      logic  in_rng;
      exp_t  e;
      lat    = int'(lat_of(k));
      in_rng = (addr >= BASE) && (((addr - BASE) >> 3) < 64'(DEPTH));
      idx    = in_rng ? int'((addr - BASE) >> 3) : 0;
      e.k    = k;
      e.cyc  = cyc + lat;
      e.data = in_rng ? model[k][idx] : '0;
      sb.push_back(e);
      if (in_rng) begin
         for (int b = 0; b < 8; b++) begin
            if (strb[b]) model[k][idx][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      dreq[k] = '{valid: 1'b1, addr: addr, size: size, strobe: strb, data: wdata};
      repeat (lat + 1) @(posedge clk);
      #1;
      dreq[k].valid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (dresp[k].addr_ok || dresp[k].data_ok) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
               n_bad++;
               $error("FAIL unexpected_resp: dut %0d responded at cycle %0d, none expected",
                      k, cyc);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("resp_dut", 64'(k), 64'(e.k));
               check("resp_cycle", 64'(cyc), 64'(e.cyc));
               check("resp_data", dresp[k].data, e.data);
               check("resp_ok_pair", {62'd0, dresp[k].addr_ok, dresp[k].data_ok}, 64'd3);
            end
         end else begin
            check("idle_data_zero", dresp[k].data, 64'd0);
         end
      end
   end

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 4; k++) dreq[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("reset_addr_ok", {63'd0, dresp[k].addr_ok}, 64'd0);
         check("reset_data_ok", {63'd0, dresp[k].data_ok}, 64'd0);
         check("reset_data", dresp[k].data, 64'd0);
      end

      // Full write then read back.
      do_req(1, BASE + 64'd8, 8'hff, 64'h1122334455667788, MSIZE8);
      do_req(1, BASE + 64'd8, 8'h00, 64'd0, MSIZE8);

      // Partial strobe into a zeroed word.
      do_req(1, BASE, 8'hff, 64'd0, MSIZE8);
      do_req(1, BASE + 64'd3, 8'h08, 64'hAB << 24, MSIZE1);
      do_req(1, BASE, 8'h00, 64'd0, MSIZE8);
      check("partial_model", model[1][0], 64'h00000000AB000000);

      // Upper-half strobe with misaligned address; low addr bits ignored.
      do_req(1, BASE + 64'd16, 8'hff, 64'hFFEEDDCCBBAA9988, MSIZE8);
      do_req(1, BASE + 64'd21, 8'hf0, 64'h0123456789ABCDEF, MSIZE4);
      do_req(1, BASE + 64'd16, 8'h00, 64'd0, MSIZE2);

      // Out of range above and below; then confirm nothing moved.
      do_req(1, BASE + 64'(DEPTH) * 64'd8, 8'h00, 64'd0, MSIZE8);
      do_req(1, BASE + 64'(DEPTH) * 64'd8, 8'hff, 64'h5555555555555555, MSIZE8);
      do_req(1, BASE - 64'd8, 8'hff, 64'h7777777777777777, MSIZE8);
      do_req(1, BASE, 8'h00, 64'd0, MSIZE8);
      do_req(1, BASE + 64'd8, 8'h00, 64'd0, MSIZE8);
      do_req(1, BASE + 64'd16, 8'h00, 64'd0, MSIZE8);

      // Latency sweep: write and read back on every DUT, back to back.
      for (int k = 0; k < 4; k++) begin
         do_req(k, BASE + 64'(8 * (k + 4)), 8'hff, {32'hC0DE0000 + 32'(k), 32'h600DF00D},
                MSIZE8);
         do_req(k, BASE + 64'(8 * (k + 4)), 8'h00, 64'd0, MSIZE8);
      end

      // Reset while a write sits in WAIT on the LATENCY=4 DUT.
      do_req(2, BASE + 64'd8, 8'hff, 64'hCAFEBABE01020304, MSIZE8);
      dreq[2] = '{valid: 1'b1, addr: BASE + 64'd8, size: MSIZE8, strobe: 8'hff,
                  data: 64'hDEADDEADDEADDEAD};
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset         = 1'b0;
      dreq[2].valid = 1'b0;
      check("midreset_addr_ok", {63'd0, dresp[2].addr_ok}, 64'd0);
      check("midreset_data", dresp[2].data, 64'd0);
      repeat (6) @(posedge clk);
      #1;
      do_req(2, BASE + 64'd8, 8'h00, 64'd0, MSIZE8);

      // Withdrawal after one cycle in WAIT on the LATENCY=5 DUT.
      do_req(3, BASE + 64'd24, 8'hff, 64'h0F0F0F0F0F0F0F0F, MSIZE8);
      dreq[3] = '{valid: 1'b1, addr: BASE + 64'd24, size: MSIZE8, strobe: 8'hff,
                  data: 64'hBADBADBADBADBAD0};
      repeat (2) @(posedge clk);
      #1;
      dreq[3].valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      do_req(3, BASE + 64'd24, 8'h00, 64'd0, MSIZE8);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
